// File: rtl/pirdsp_cfg_pkg.sv
// Shared types and defaults for PIRDSP slice configuration sequencing.
package pirdsp_cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  localparam int unsigned PIRDSP_CFG_WIDTH     = 16;
  localparam int unsigned PIRDSP_SETTLE_CYCLES = 3;

endpackage

// File: rtl/dsp_config_loader.sv
// Serial config sequencer: shifts a captured word LSB-first into one DSP slice
// chain and holds the slice clock enables low until the pipeline has settled.
module dsp_config_loader
  import pirdsp_cfg_pkg::*;
#(
  parameter int unsigned CFG_WIDTH     = PIRDSP_CFG_WIDTH,
  parameter int unsigned SETTLE_CYCLES = PIRDSP_SETTLE_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CFG_WIDTH-1:0] cfg_word,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic                 cfg_abort,
  output logic                 configuration_input,
  output logic                 configuration_enable,
  output logic                 dsp_ce,
  output logic                 busy,
  output logic                 done,
  output logic                 cfg_loaded
);

  localparam int unsigned BIT_W = (CFG_WIDTH > 1) ? $clog2(CFG_WIDTH) : 1;
  localparam int unsigned SET_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CFG_WIDTH - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);

  state_t                 state;
  logic [CFG_WIDTH-1:0]   shreg;
  logic [BIT_W-1:0]       bit_cnt;
  logic [SET_W-1:0]       settle_cnt;

  // Bit 0 is driven straight from cfg_word on capture, so the shift register
  // only holds the bits still to be sent.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state                <= ST_IDLE;
      shreg                <= '0;
      bit_cnt              <= '0;
      settle_cnt           <= '0;
      cfg_ready            <= 1'b1;
      configuration_input  <= 1'b0;
      configuration_enable <= 1'b0;
      dsp_ce               <= 1'b1;
      busy                 <= 1'b0;
      done                 <= 1'b0;
      cfg_loaded           <= 1'b0;
    end else begin
      done <= 1'b0;
      if (cfg_abort && (state != ST_IDLE)) begin
        state                <= ST_IDLE;
        cfg_ready            <= 1'b1;
        configuration_input  <= 1'b0;
        configuration_enable <= 1'b0;
        dsp_ce               <= 1'b1;
        busy                 <= 1'b0;
        cfg_loaded           <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (cfg_valid) begin
              state                <= ST_SHIFT;
              shreg                <= cfg_word >> 1;
              bit_cnt              <= '0;
              configuration_input  <= cfg_word[0];
              configuration_enable <= 1'b1;
              dsp_ce               <= 1'b0;
              cfg_ready            <= 1'b0;
              busy                 <= 1'b1;
            end
          end
          ST_SHIFT: begin
            if (bit_cnt == BIT_LAST) begin
              state                <= ST_SETTLE;
              settle_cnt           <= '0;
              configuration_input  <= 1'b0;
              configuration_enable <= 1'b0;
            end else begin
              bit_cnt             <= bit_cnt + BIT_W'(1);
              configuration_input <= shreg[0];
              shreg               <= shreg >> 1;
            end
          end
          ST_SETTLE: begin
            if (settle_cnt == SET_LAST) begin
              state      <= ST_IDLE;
              cfg_ready  <= 1'b1;
              dsp_ce     <= 1'b1;
              busy       <= 1'b0;
              done       <= 1'b1;
              cfg_loaded <= 1'b1;
            end else begin
              settle_cnt <= settle_cnt + SET_W'(1);
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dsp_config_loader.sv
// Bench for dsp_config_loader: directed scenarios plus random traffic against a
// timestamp-based reference model of the load sequence.
module tb_dsp_config_loader;

  localparam int unsigned W = 8;
  localparam int unsigned S = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] cfg_word;
  logic         cfg_valid;
  logic         cfg_ready;
  logic         cfg_abort;
  logic         configuration_input;
  logic         configuration_enable;
  logic         dsp_ce;
  logic         busy;
  logic         done;
  logic         cfg_loaded;

  dsp_config_loader #(.CFG_WIDTH(W), .SETTLE_CYCLES(S)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .cfg_word             (cfg_word),
    .cfg_valid            (cfg_valid),
    .cfg_ready            (cfg_ready),
    .cfg_abort            (cfg_abort),
    .configuration_input  (configuration_input),
    .configuration_enable (configuration_enable),
    .dsp_ce               (dsp_ce),
    .busy                 (busy),
    .done                 (done),
    .cfg_loaded           (cfg_loaded)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a load accepted at edge t0 occupies cycles t0+1..t0+W+S.
  int           cyc       = 0;
  bit           m_valid   = 1'b0;
  bit           m_active  = 1'b0;
  int           m_t0      = 0;
  logic [W-1:0] m_word    = '0;
  bit           m_loaded  = 1'b0;
  bit           m_done    = 1'b0;
  int           done_seen = 0;
  int           done_exp  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic check_outputs();
    int  k;
    bit  e_en, e_in;
    k    = cyc - m_t0;
    e_en = m_active && (k >= 1) && (k <= W);
    e_in = e_en ? m_word[k-1] : 1'b0;
    check_eq("cfg_ready",  32'(cfg_ready),            32'(!m_active));
    check_eq("cfg_en",     32'(configuration_enable), 32'(e_en));
    check_eq("cfg_in",     32'(configuration_input),  32'(e_in));
    check_eq("dsp_ce",     32'(dsp_ce),               32'(!m_active));
    check_eq("busy",       32'(busy),                 32'(m_active));
    check_eq("done",       32'(done),                 32'(m_done));
    check_eq("cfg_loaded", 32'(cfg_loaded),           32'(m_loaded));
  endtask

  task automatic model_edge(input bit v, input logic [W-1:0] w, input bit ab, input bit rn);
    bit was_active;
    was_active = m_active;
    m_done     = 1'b0;
    if (!rn) begin
      m_active = 1'b0;
      m_loaded = 1'b0;
      m_valid  = 1'b1;
    end else if (was_active && ab) begin
      m_active = 1'b0;
      m_loaded = 1'b0;
    end else if (was_active && (cyc - m_t0 == int'(W + S))) begin
      m_active = 1'b0;
      m_loaded = 1'b1;
      m_done   = 1'b1;
      done_exp++;
    end else if (!was_active && v) begin
      m_active = 1'b1;
      m_t0     = cyc;
      m_word   = w;
    end
  endtask

  // One clock: check current outputs, apply inputs, advance the model at the edge.
  task automatic step(input bit v, input logic [W-1:0] w, input bit ab, input bit rn);
    @(negedge clk);
    if (m_valid) begin
      check_outputs();
      if (done === 1'b1) done_seen++;
    end
    cfg_valid = v;
    cfg_word  = w;
    cfg_abort = ab;
    rst_n     = rn;
    @(posedge clk);
    model_edge(v, w, ab, rn);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_word = '0; cfg_abort = 1'b0;

    // Reset, with a valid word and abort present to show reset dominates.
    step(1'b1, 8'hFF, 1'b1, 1'b0);
    step(1'b1, 8'hFF, 1'b1, 1'b0);
    idle(2);
    step(1'b0, '0, 1'b1, 1'b1);    // abort in IDLE is ignored
    idle(1);

    // 0xA5 with an ignored 0x3C offer at T+4, then 0x0F waiting to go back-to-back.
    done_seen = 0;
    done_exp  = 0;
    step(1'b1, 8'hA5, 1'b0, 1'b1);  // T
    idle(3);                        // T+1..T+3
    step(1'b1, 8'h3C, 1'b0, 1'b1);  // T+4 ignored
    idle(6);                        // T+5..T+10
    step(1'b0, '0, 1'b0, 1'b1);     // T+11
    step(1'b1, 8'h0F, 1'b0, 1'b1);  // T+12 accepted
    idle(14);
    check_eq("done_count_b2b", 32'(done_seen), 32'(2));
    check_eq("done_count_model", 32'(done_seen), 32'(done_exp));

    // Abort mid-shift.
    step(1'b1, 8'h5A, 1'b0, 1'b1);
    idle(4);
    step(1'b0, '0, 1'b1, 1'b1);
    idle(3);
    check_eq("loaded_after_abort", 32'(cfg_loaded), 32'(0));

    // Full load, then abort on the final settle edge.
    step(1'b1, 8'h81, 1'b0, 1'b1);
    idle(W + S - 1);
    step(1'b0, '0, 1'b1, 1'b1);
    idle(3);

    // Reset during settle.
    step(1'b1, 8'hC3, 1'b0, 1'b1);
    idle(9);
    step(1'b0, '0, 1'b0, 1'b0);
    idle(3);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 3) != 0), W'($urandom), ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 199) != 0));
    end
    idle(W + S + 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
